// File: rtl/sync_fifo_chk.sv
// Synchronous FIFO with registered status flags and overflow/underflow checking.
// Violations pulse for one cycle and are tallied in saturating counters.
module sync_fifo_chk #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err,
  output logic                     udf_err,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         udf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push_ok, pop_ok, ovf_hit, udf_hit;

  // A push into a full FIFO is legal when a pop frees the head slot in the same cycle.
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop);
    ovf_hit = push && full && !pop;
    udf_hit = pop && empty;
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + CW'(1);
    else if (pop_ok && !push_ok)
      count_nxt = count - CW'(1);
  end

  // Storage is never cleared; reset only forgets the contents via the pointers.
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      ovf_err      <= 1'b0;
      udf_err      <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      ovf_err      <= ovf_hit;
      udf_err      <= udf_hit;
    end
  end

  // A clear coinciding with a violation leaves that violation counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (err_clr)
        ovf_cnt <= {{(CNT_W-1){1'b0}}, ovf_hit};
      else if (ovf_hit && ovf_cnt != CNT_MAX)
        ovf_cnt <= ovf_cnt + CNT_W'(1);

      if (err_clr)
        udf_cnt <= {{(CNT_W-1){1'b0}}, udf_hit};
      else if (udf_hit && udf_cnt != CNT_MAX)
        udf_cnt <= udf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/sync_fifo_chk.md
SYNC_FIFO_CHK -- requirements
Module: sync_fifo_chk

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, entry count, power of 2, minimum 2.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have parameter CNT_W, default 8, width of the violation counters.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset.
REQ-007 The block SHALL have port clk, input, 1 bit: sole clock, all state updates on its posedge.
REQ-008 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-009 The block SHALL have port push, input, 1 bit: write request.
REQ-010 The block SHALL have port din, input, WIDTH bits: write data.
REQ-011 The block SHALL have port pop, input, 1 bit: read request.
REQ-012 The block SHALL have port err_clr, input, 1 bit: clears the violation counters.
REQ-013 The block SHALL have port dout, output, WIDTH bits: last popped word.
REQ-014 The block SHALL have ports full and empty, outputs, 1 bit each: occupancy == DEPTH and occupancy == 0.
REQ-015 The block SHALL have ports almost_full and almost_empty, outputs, 1 bit each: threshold flags.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-017 The block SHALL have ports ovf_err and udf_err, outputs, 1 bit each: single-cycle violation pulses.
REQ-018 The block SHALL have ports ovf_cnt and udf_cnt, outputs, CNT_W bits each: saturating violation counts.

Function
REQ-019 The block SHALL accept a push only when push=1 and (full=0, or full=1 with pop=1); an accepted push writes din at the write pointer.
REQ-020 The block SHALL accept a pop only when pop=1 and empty=0; on an accepted pop, dout SHALL present the head word from the cycle after the edge and hold it until the next accepted pop.
REQ-021 The block SHALL wrap read and write pointers modulo DEPTH.
REQ-022 The block SHALL update count as +1 on push only, -1 on pop only, and leave it unchanged on both or neither.
REQ-023 The block SHALL register all status flags, consistent with count in the same cycle, with no combinational path from inputs to any output.
REQ-024 On full with push=1 and pop=1, the block SHALL accept both, leave count at DEPTH, and raise no overflow.
REQ-025 On empty with push=1 and pop=1, the block SHALL accept the push, reject the pop (dout unchanged), and make count 1.
REQ-026 On a rejected push (push=1, full=1, pop=0), the block SHALL pulse ovf_err high for one cycle after the edge, leave memory, pointers and count unchanged, and increment ovf_cnt.
REQ-027 On a rejected pop (pop=1, empty=1), the block SHALL pulse udf_err high for one cycle after the edge, leave dout and state unchanged, and increment udf_cnt.
REQ-028 The block SHALL saturate ovf_cnt and udf_cnt at 2^CNT_W-1.
REQ-029 When err_clr=1, the block SHALL load each counter with 1 if its violation occurs in the same cycle, otherwise 0; err_clr SHALL not affect FIFO data or state.

Reset
REQ-030 When rst=1 at a posedge, the block SHALL clear pointers, count, dout, ovf_err, udf_err, ovf_cnt and udf_cnt to 0, set empty=1 and almost_empty=1, and set full=0 and almost_full=0.
REQ-031 The block SHALL give rst priority over push, pop and err_clr, SHALL not record a violation in a reset cycle, and SHALL discard FIFO contents on reset mid-operation without clearing storage memory.

Verification
REQ-032 The bench SHALL cover: after reset, push 0x01..0x10 (DEPTH=16) -> full=1 after the 16th, count=16, almost_full=1 from count 14; pop 16 -> dout 0x01..0x10 in order, then empty=1.
REQ-033 The bench SHALL cover: full, push=1 pop=0 for 3 cycles -> ovf_err pulses 3 times, ovf_cnt=3, count stays 16; then push+pop with din=0xAA -> count 16, 0xAA emerges as the last word.
REQ-034 The bench SHALL cover: empty, pop=1 -> udf_err=1 for one cycle, udf_cnt=1, dout unchanged; then push+pop with din=0x55 -> count=1, udf_cnt=2.
REQ-035 The bench SHALL cover: 40 pushes and 40 pops with pointer wrap at occupancy 5 -> data order preserved, no errors.
REQ-036 The bench SHALL cover: CNT_W=2 with 5 overflows -> ovf_cnt=3; err_clr with an overflow in the same cycle -> ovf_cnt=1.
REQ-037 The bench SHALL cover: rst asserted at count=7 -> next cycle count=0, empty=1, dout=0; following push/pop of 0x3C returns 0x3C.
